mccpu_ctrl_hs: RTL and testbench



---
 rtl/mccpu_ctrl_hs_if.sv | 41 ++++
 rtl/mccpu_ctrl_hs.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mccpu_ctrl_hs.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mccpu_ctrl_hs_if.sv
// Control bundle between the multicycle controller and its datapath.
interface mccpu_ctrl_hs_if #(
  parameter int unsigned ALUOP_W = 4
);
  logic               Zero;
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               mem_ready;
  logic               RegWrite;
  logic               MemWrite;
  logic               MemRead;
  logic               PCWrite;
  logic               IRWrite;
  logic               IorD;
  logic               EXTOp;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic [1:0]         GPRSel;
  logic [1:0]         WDSel;
  logic               exc_illegal;
  logic               exc_bus;
  logic [2:0]         state_o;

  // Controller side: consumes datapath status, drives control lines.
  modport master (
    input  Zero, Op, Funct, mem_ready,
    output RegWrite, MemWrite, MemRead, PCWrite, IRWrite, IorD, EXTOp,
           ALUOp, ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel,
           exc_illegal, exc_bus, state_o
  );

  // Datapath side: supplies status, receives control lines.
  modport slave (
    output Zero, Op, Funct, mem_ready,
    input  RegWrite, MemWrite, MemRead, PCWrite, IRWrite, IorD, EXTOp,
           ALUOp, ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel,
           exc_illegal, exc_bus, state_o
  );
endinterface

// File: rtl/mccpu_ctrl_hs.sv
// Multicycle MIPS controller with wait-capable memory, optional jr/jalr,
// and a TRAP state for illegal instructions and memory timeouts.
module mccpu_ctrl_hs #(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned HAS_JR      = 1,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  mccpu_ctrl_hs_if.master  bus
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  state_t            state;
  state_t            nxt;
  state_t            st_eff;
  logic [WCNT_W-1:0] wcnt;
  logic              cause_ill;
  logic              cause_bus;

  logic              dec_legal;
  logic [3:0]        dec_alu;
  logic              is_j, is_jal, is_beq, is_bne, is_lw, is_sw;
  logic              is_imm, is_zext, is_jr, is_jalr, is_shamt;

  logic              mem_wait;
  logic              timeout_hit;
  logic              trap_ill, trap_bus;

  logic              reg_write, mem_write, mem_read, pc_write, ir_write, iord, ext_op;
  logic [3:0]        alu_op;
  logic [1:0]        src_a, src_b, pc_src, gpr_sel, wd_sel;
  logic              exc_ill, exc_bus;

  // Instruction decode: legality, instruction class and ALU operation.
  always_comb begin
    dec_legal = 1'b1;
    dec_alu   = ALU_ADD;
    is_j      = 1'b0;
    is_jal    = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_imm    = 1'b0;
    is_zext   = 1'b0;
    is_jr     = 1'b0;
    is_jalr   = 1'b0;
    is_shamt  = 1'b0;
    case (bus.Op)
      OP_RTYPE: begin
        case (bus.Funct)
          FN_SLL:  begin dec_alu = ALU_SLL; is_shamt = 1'b1; end
          FN_SRL:  begin dec_alu = ALU_SRL; is_shamt = 1'b1; end
          FN_SLLV: dec_alu = ALU_SLL;
          FN_SRLV: dec_alu = ALU_SRL;
          FN_JR:   begin
            if (HAS_JR != 0) is_jr = 1'b1;
            else             dec_legal = 1'b0;
          end
          FN_JALR: begin
            if (HAS_JR != 0) is_jalr = 1'b1;
            else             dec_legal = 1'b0;
          end
          FN_ADD, FN_ADDU: dec_alu = ALU_ADD;
          FN_SUB, FN_SUBU: dec_alu = ALU_SUB;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_NOR:  dec_alu = ALU_NOR;
          FN_SLT:  dec_alu = ALU_SLT;
          FN_SLTU: dec_alu = ALU_SLTU;
          default: dec_legal = 1'b0;
        endcase
      end
      OP_J:    is_j = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      OP_BEQ:  begin is_beq = 1'b1; dec_alu = ALU_SUB; end
      OP_BNE:  begin is_bne = 1'b1; dec_alu = ALU_SUB; end
      OP_ADDI: begin is_imm = 1'b1; dec_alu = ALU_ADD; end
      OP_SLTI: begin is_imm = 1'b1; dec_alu = ALU_SLT; end
      OP_ANDI: begin is_imm = 1'b1; is_zext = 1'b1; dec_alu = ALU_AND; end
      OP_ORI:  begin is_imm = 1'b1; is_zext = 1'b1; dec_alu = ALU_OR; end
      OP_LUI:  begin is_imm = 1'b1; dec_alu = ALU_LUI; end
      OP_LW:   is_lw = 1'b1;
      OP_SW:   is_sw = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // Memory wait detection; ready in the same cycle beats the timeout.
  assign mem_wait    = ((state == S_IF) || (state == S_MEM)) && !bus.mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait &&
                       (wcnt == WCNT_W'(MEM_TIMEOUT - 1));

  // Next state and control outputs; reset presents IF with enables forced off.
  always_comb begin
    st_eff    = rst ? S_IF : state;
    nxt       = S_IF;
    trap_ill  = 1'b0;
    trap_bus  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    iord      = 1'b0;
    ext_op    = 1'b1;
    alu_op    = ALU_ADD;
    src_a     = 2'b01;
    src_b     = 2'b00;
    pc_src    = 2'b00;
    gpr_sel   = 2'b00;
    wd_sel    = 2'b00;
    case (st_eff)
      S_IF: begin
        mem_read = 1'b1;
        src_a    = 2'b00;
        src_b    = 2'b01;
        pc_write = bus.mem_ready;
        ir_write = bus.mem_ready;
        if (bus.mem_ready) nxt = S_ID;
        else if (timeout_hit) begin nxt = S_TRAP; trap_bus = 1'b1; end
        else nxt = S_IF;
      end
      S_ID: begin
        if (is_j || is_jal) begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
          if (is_jal) begin
            reg_write = 1'b1;
            wd_sel    = 2'b10;
            gpr_sel   = 2'b10;
          end
          nxt = S_IF;
        end else if (!dec_legal) begin
          nxt      = S_TRAP;
          trap_ill = 1'b1;
        end else begin
          src_a = 2'b00;
          src_b = 2'b11;
          nxt   = S_EXE;
        end
      end
      S_EXE: begin
        alu_op = dec_alu;
        if (is_beq || is_bne) begin
          pc_src   = 2'b01;
          pc_write = (is_beq && bus.Zero) || (is_bne && !bus.Zero);
          nxt      = S_IF;
        end else if (is_jr || is_jalr) begin
          src_b    = 2'b00;
          pc_src   = 2'b00;
          pc_write = 1'b1;
          if (is_jalr) begin
            reg_write = 1'b1;
            wd_sel    = 2'b10;
            gpr_sel   = 2'b00;
          end
          nxt = S_IF;
        end else if (is_lw || is_sw) begin
          src_b = 2'b10;
          nxt   = S_MEM;
        end else if (is_shamt) begin
          src_a = 2'b10;
          nxt   = S_WB;
        end else if (is_imm) begin
          src_b  = 2'b10;
          ext_op = !is_zext;
          nxt    = S_WB;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (bus.mem_ready) nxt = is_lw ? S_WB : S_IF;
        else if (timeout_hit) begin nxt = S_TRAP; trap_bus = 1'b1; end
        else nxt = S_MEM;
      end
      S_WB: begin
        reg_write = 1'b1;
        wd_sel    = is_lw ? 2'b01 : 2'b00;
        gpr_sel   = (is_lw || is_imm) ? 2'b01 : 2'b00;
        nxt       = S_IF;
      end
      S_TRAP: begin
        pc_src   = 2'b11;
        pc_write = 1'b1;
        nxt      = S_IF;
      end
      default: nxt = S_IF;
    endcase
    if (rst) begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
    end
    exc_ill = (st_eff == S_TRAP) && cause_ill;
    exc_bus = (st_eff == S_TRAP) && cause_bus;
  end

  // State, wait counter and trap cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IF;
      wcnt      <= '0;
      cause_ill <= 1'b0;
      cause_bus <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)  wcnt <= '0;
      else if (mem_wait) wcnt <= WCNT_W'(wcnt + 1'b1);
      cause_ill <= (nxt == S_TRAP) && trap_ill;
      cause_bus <= (nxt == S_TRAP) && trap_bus;
    end
  end

  assign bus.RegWrite    = reg_write;
  assign bus.MemWrite    = mem_write;
  assign bus.MemRead     = mem_read;
  assign bus.PCWrite     = pc_write;
  assign bus.IRWrite     = ir_write;
  assign bus.IorD        = iord;
  assign bus.EXTOp       = ext_op;
  assign bus.ALUOp       = ALUOP_W'(alu_op);
  assign bus.ALUSrcA     = src_a;
  assign bus.ALUSrcB     = src_b;
  assign bus.PCSource    = pc_src;
  assign bus.GPRSel      = gpr_sel;
  assign bus.WDSel       = wd_sel;
  assign bus.exc_illegal = exc_ill;
  assign bus.exc_bus     = exc_bus;
  assign bus.state_o     = st_eff;

endmodule

// File: tb/tb_mccpu_ctrl_hs.sv
// Directed scoreboard bench for mccpu_ctrl_hs: two instances (jr enabled with
// timeout 4, jr disabled with timeout 8) run the same instruction stream.
module tb_mccpu_ctrl_hs;

  localparam int A = 0;
  localparam int B = 1;

  localparam int F_ST = 0, F_RW = 1, F_MW = 2, F_MR = 3, F_PCW = 4, F_IRW = 5,
                 F_IORD = 6, F_EXT = 7, F_ALUOP = 8, F_SRCA = 9, F_SRCB = 10,
                 F_PCS = 11, F_GPR = 12, F_WDS = 13, F_EXI = 14, F_EXB = 15,
                 F_WC = 16, NF = 17;

  typedef struct {
    string tag;
    int    d;
    int    f;
    int    v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] fn;
  logic       zero;
  logic       rdy;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  int   oa[NF];
  int   ob[NF];

  mccpu_ctrl_hs_if #(.ALUOP_W(4)) ifa ();
  mccpu_ctrl_hs_if #(.ALUOP_W(4)) ifb ();

  assign ifa.Op = op;  assign ifa.Funct = fn;  assign ifa.Zero = zero;  assign ifa.mem_ready = rdy;
  assign ifb.Op = op;  assign ifb.Funct = fn;  assign ifb.Zero = zero;  assign ifb.mem_ready = rdy;

  mccpu_ctrl_hs #(.ALUOP_W(4), .HAS_JR(1), .MEM_TIMEOUT(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mccpu_ctrl_hs #(.ALUOP_W(4), .HAS_JR(0), .MEM_TIMEOUT(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flatten observed outputs of each instance for field-indexed comparison.
  always_comb begin
    oa[F_ST] = int'(ifa.state_o);   oa[F_RW] = int'(ifa.RegWrite);  oa[F_MW] = int'(ifa.MemWrite);
    oa[F_MR] = int'(ifa.MemRead);   oa[F_PCW] = int'(ifa.PCWrite);  oa[F_IRW] = int'(ifa.IRWrite);
    oa[F_IORD] = int'(ifa.IorD);    oa[F_EXT] = int'(ifa.EXTOp);    oa[F_ALUOP] = int'(ifa.ALUOp);
    oa[F_SRCA] = int'(ifa.ALUSrcA); oa[F_SRCB] = int'(ifa.ALUSrcB); oa[F_PCS] = int'(ifa.PCSource);
    oa[F_GPR] = int'(ifa.GPRSel);   oa[F_WDS] = int'(ifa.WDSel);    oa[F_EXI] = int'(ifa.exc_illegal);
    oa[F_EXB] = int'(ifa.exc_bus);  oa[F_WC] = int'(dut_a.wcnt);
  end

  always_comb begin
    ob[F_ST] = int'(ifb.state_o);   ob[F_RW] = int'(ifb.RegWrite);  ob[F_MW] = int'(ifb.MemWrite);
    ob[F_MR] = int'(ifb.MemRead);   ob[F_PCW] = int'(ifb.PCWrite);  ob[F_IRW] = int'(ifb.IRWrite);
    ob[F_IORD] = int'(ifb.IorD);    ob[F_EXT] = int'(ifb.EXTOp);    ob[F_ALUOP] = int'(ifb.ALUOp);
    ob[F_SRCA] = int'(ifb.ALUSrcA); ob[F_SRCB] = int'(ifb.ALUSrcB); ob[F_PCS] = int'(ifb.PCSource);
    ob[F_GPR] = int'(ifb.GPRSel);   ob[F_WDS] = int'(ifb.WDSel);    ob[F_EXI] = int'(ifb.exc_illegal);
    ob[F_EXB] = int'(ifb.exc_bus);  ob[F_WC] = int'(dut_b.wcnt);
  end

  task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic r, input logic rs);
    @(negedge clk);
    op = o; fn = f; zero = z; rdy = r; rst = rs;
  endtask

  task automatic ex(input string t, input int d, input int f, input int v);
    exp_t e;
    e.tag = t; e.d = d; e.f = f; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic ex2(input string t, input int f, input int v);
    ex(t, A, f, v);
    ex(t, B, f, v);
  endtask

  task automatic chk();
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      int   got;
      e   = exp_q.pop_front();
      got = (e.d == A) ? oa[e.f] : ob[e.f];
      n_tests++;
      assert (got === e.v) else begin
        n_fail++;
        $error("FAIL %s dut%0d: observed %0d expected %0d", e.tag, e.d, got, e.v);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; op = 6'h00; fn = 6'h00; zero = 1'b0; rdy = 1'b1;

    // Reset: IF values, enables forced off even with ready high
    cyc(6'h00, 6'h00, 1'b0, 1'b1, 1'b1);
    ex2("rst_st", F_ST, 0); ex2("rst_pcw", F_PCW, 0); ex2("rst_irw", F_IRW, 0);
    ex2("rst_rw", F_RW, 0); ex2("rst_mr", F_MR, 1); ex2("rst_srca", F_SRCA, 0);
    ex2("rst_srcb", F_SRCB, 1); ex2("rst_aluop", F_ALUOP, 1); ex2("rst_exb", F_EXB, 0);
    chk();

    // add: IF ID EXE WB
    cyc(6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
    ex2("add_if_st", F_ST, 0); ex2("add_if_pcw", F_PCW, 1); ex2("add_if_irw", F_IRW, 1);
    ex2("add_if_wc", F_WC, 0); chk();
    cyc(6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
    ex2("add_id_st", F_ST, 1); ex2("add_id_srca", F_SRCA, 0); ex2("add_id_srcb", F_SRCB, 3); chk();
    cyc(6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
    ex2("add_exe_st", F_ST, 2); ex2("add_exe_aluop", F_ALUOP, 1); ex2("add_exe_srcb", F_SRCB, 0); chk();
    cyc(6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
    ex2("add_wb_st", F_ST, 4); ex2("add_wb_rw", F_RW, 1); ex2("add_wb_gpr", F_GPR, 0);
    ex2("add_wb_wds", F_WDS, 0); chk();

    // lw with 3 not-ready MEM cycles
    cyc(6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("lw_if_st", F_ST, 0); chk();
    cyc(6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("lw_id_st", F_ST, 1); chk();
    cyc(6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("lw_exe_st", F_ST, 2); ex2("lw_exe_srcb", F_SRCB, 2); ex2("lw_exe_aluop", F_ALUOP, 1); chk();
    for (int i = 0; i < 4; i++) begin
      cyc(6'h23, 6'h00, 1'b0, (i == 3), 1'b0);
      ex2("lw_mem_st", F_ST, 3); ex2("lw_mem_mr", F_MR, 1); ex2("lw_mem_iord", F_IORD, 1);
      ex2("lw_mem_mw", F_MW, 0); ex("lw_mem_wc", B, F_WC, i); chk();
    end
    cyc(6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("lw_wb_st", F_ST, 4); ex2("lw_wb_wds", F_WDS, 1); ex2("lw_wb_gpr", F_GPR, 1);
    ex2("lw_wb_rw", F_RW, 1); chk();

    // Fetch timeout: A traps after 4 not-ready IF cycles, B (limit 8) keeps waiting
    for (int i = 0; i < 4; i++) begin
      cyc(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
      ex2("to_if_st", F_ST, 0); ex2("to_if_pcw", F_PCW, 0); ex("to_if_wc", A, F_WC, i); chk();
    end
    cyc(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
    ex("to_trap_st", A, F_ST, 5); ex("to_trap_exb", A, F_EXB, 1); ex("to_trap_exi", A, F_EXI, 0);
    ex("to_trap_pcs", A, F_PCS, 3); ex("to_trap_pcw", A, F_PCW, 1);
    ex("to_b_wait_st", B, F_ST, 0); ex("to_b_exb", B, F_EXB, 0); chk();
    cyc(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
    ex("to_back_st", A, F_ST, 0); ex("to_back_exb", A, F_EXB, 0); ex("to_back_wc", A, F_WC, 0);
    ex("to_b_wait2_st", B, F_ST, 0); chk();
    cyc(6'h00, 6'h00, 1'b0, 1'b0, 1'b1);

    // Ready on the 4th fetch cycle wins over the timeout; then illegal Op 3F
    for (int i = 0; i < 3; i++) begin
      cyc(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
      ex2("rdy4_wait_st", F_ST, 0); chk();
    end
    cyc(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("rdy4_st", F_ST, 0); ex2("rdy4_pcw", F_PCW, 1); ex2("rdy4_irw", F_IRW, 1); chk();
    cyc(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("ill_id_st", F_ST, 1); ex2("ill_id_exb", F_EXB, 0); chk();
    cyc(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("ill_trap_st", F_ST, 5); ex2("ill_trap_exi", F_EXI, 1); ex2("ill_trap_exb", F_EXB, 0);
    ex2("ill_trap_pcs", F_PCS, 3); ex2("ill_trap_pcw", F_PCW, 1); chk();
    cyc(6'h00, 6'h08, 1'b0, 1'b1, 1'b0);
    ex2("ill_back_st", F_ST, 0); ex2("ill_back_exi", F_EXI, 0); chk();

    // jr: legal on A, illegal on B
    cyc(6'h00, 6'h08, 1'b0, 1'b1, 1'b0);
    ex2("jr_id_st", F_ST, 1); chk();
    cyc(6'h00, 6'h08, 1'b0, 1'b1, 1'b0);
    ex("jr_a_st", A, F_ST, 2); ex("jr_a_pcw", A, F_PCW, 1); ex("jr_a_pcs", A, F_PCS, 0);
    ex("jr_a_srcb", A, F_SRCB, 0); ex("jr_a_rw", A, F_RW, 0);
    ex("jr_b_st", B, F_ST, 5); ex("jr_b_exi", B, F_EXI, 1); chk();

    // jal: 2 cycles, link write in ID
    cyc(6'h03, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("jal_if_st", F_ST, 0); chk();
    cyc(6'h03, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("jal_id_st", F_ST, 1); ex2("jal_pcs", F_PCS, 2); ex2("jal_pcw", F_PCW, 1);
    ex2("jal_rw", F_RW, 1); ex2("jal_wds", F_WDS, 2); ex2("jal_gpr", F_GPR, 2); chk();

    // beq taken with Zero=1
    cyc(6'h04, 6'h00, 1'b1, 1'b1, 1'b0);
    ex2("beq_if_st", F_ST, 0); chk();
    cyc(6'h04, 6'h00, 1'b1, 1'b1, 1'b0);
    ex2("beq_id_st", F_ST, 1); chk();
    cyc(6'h04, 6'h00, 1'b1, 1'b1, 1'b0);
    ex2("beq_exe_st", F_ST, 2); ex2("beq_pcw", F_PCW, 1); ex2("beq_pcs", F_PCS, 1);
    ex2("beq_aluop", F_ALUOP, 2); chk();

    // bne not taken with Zero=1
    cyc(6'h05, 6'h00, 1'b1, 1'b1, 1'b0);
    ex2("bne_if_st", F_ST, 0); chk();
    cyc(6'h05, 6'h00, 1'b1, 1'b1, 1'b0);
    ex2("bne_id_st", F_ST, 1); chk();
    cyc(6'h05, 6'h00, 1'b1, 1'b1, 1'b0);
    ex2("bne_exe_st", F_ST, 2); ex2("bne_pcw", F_PCW, 0); ex2("bne_pcs", F_PCS, 1); chk();

    // ori: zero-extended immediate, writes rt
    cyc(6'h0D, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("ori_if_st", F_ST, 0); chk();
    cyc(6'h0D, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("ori_id_st", F_ST, 1); chk();
    cyc(6'h0D, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("ori_ext", F_EXT, 0); ex2("ori_srcb", F_SRCB, 2); ex2("ori_aluop", F_ALUOP, 4); chk();
    cyc(6'h0D, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("ori_wb_st", F_ST, 4); ex2("ori_wb_gpr", F_GPR, 1); ex2("ori_wb_wds", F_WDS, 0); chk();

    // sll (nop encoding) is legal and uses shamt
    cyc(6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("sll_if_st", F_ST, 0); chk();
    cyc(6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("sll_id_st", F_ST, 1); chk();
    cyc(6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("sll_exe_st", F_ST, 2); ex2("sll_srca", F_SRCA, 2); ex2("sll_aluop", F_ALUOP, 7); chk();
    cyc(6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("sll_wb_st", F_ST, 4); ex2("sll_wb_gpr", F_GPR, 0); chk();

    // sw stalled in MEM, aborted by reset
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("sw_if_st", F_ST, 0); chk();
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("sw_id_st", F_ST, 1); chk();
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0);
    ex2("sw_exe_st", F_ST, 2); ex2("sw_exe_srcb", F_SRCB, 2); chk();
    cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0);
    ex2("sw_mem_st", F_ST, 3); ex2("sw_mem_mw", F_MW, 1); ex2("sw_mem_iord", F_IORD, 1);
    ex2("sw_mem_mr", F_MR, 0); chk();
    cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b1);
    ex2("sw_rst_st", F_ST, 0); ex2("sw_rst_mw", F_MW, 0); ex2("sw_rst_iord", F_IORD, 0); chk();
    cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0);
    ex2("sw_after_st", F_ST, 0); ex2("sw_after_mw", F_MW, 0); ex2("sw_after_wc", F_WC, 0);
    ex2("sw_after_irw", F_IRW, 0); chk();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
